// File: rtl/sync_debounce_edge.sv
// ---------------------------------------------------------------------------
// sync_debounce_edge
//
// Input conditioning stage for an asynchronous, possibly bouncing level
// (push-button or external strobe). The raw level is brought into the clk
// domain through a flop chain. A four-state qualifier then accepts a new
// level only after STABLE_CYCLES consecutive equal synchronised samples.
// The result is a clean registered level plus one-cycle rise/fall pulses.
//
// Parameters:
//   SYNC_STAGES   synchroniser depth, 2..4
//   STABLE_CYCLES consecutive equal samples needed to accept a level,
//                 2..(2^CNT_W - 1)
//   CNT_W         stability counter width
//
// Ports:
//   clk         rising-edge system clock
//   reset       synchronous active-high reset
//   data_in     asynchronous raw level
//   data_out    debounced, synchronised level (registered)
//   rise_pulse  one cycle high when data_out goes 0->1 (registered)
//   fall_pulse  one cycle high when data_out goes 1->0 (registered)
//   busy        high while a level change is being qualified
// ---------------------------------------------------------------------------
module sync_debounce_edge #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   output logic data_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      WAIT_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      WAIT_LOW    = 2'd3
   } state_e;

   // Count value on the final qualifying edge; the first sample that leaves a
   // stable state already counts as 1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;

   state_e                 state_q;
   state_e                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   data_out_q;
   logic                   data_out_d;
   logic                   rise_pulse_q;
   logic                   rise_pulse_d;
   logic                   fall_pulse_q;
   logic                   fall_pulse_d;

   // ------------------------------------------------------------------------
   // Synchroniser: stage 0 samples the raw input, the last stage feeds the
   // qualifier.
   // ------------------------------------------------------------------------
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], data_in};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // Qualifier next-state and output logic.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_out_d   = data_out_q;
      rise_pulse_d = 1'b0;
      fall_pulse_d = 1'b0;

      unique case (state_q)
         STABLE_LOW: begin
            if (s) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end
         end

         WAIT_HIGH: begin
            if (!s) begin
               // Opposite sample: glitch rejected, qualification restarts.
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = STABLE_HIGH;
               cnt_d        = '0;
               data_out_d   = 1'b1;
               rise_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         STABLE_HIGH: begin
            if (!s) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end
         end

         WAIT_LOW: begin
            if (s) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = STABLE_LOW;
               cnt_d        = '0;
               data_out_d   = 1'b0;
               fall_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d    = STABLE_LOW;
            cnt_d      = '0;
            data_out_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers; reset overrides every other event.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q       <= '0;
         state_q      <= STABLE_LOW;
         cnt_q        <= '0;
         data_out_q   <= 1'b0;
         rise_pulse_q <= 1'b0;
         fall_pulse_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         rise_pulse_q <= rise_pulse_d;
         fall_pulse_q <= fall_pulse_d;
      end
   end

   assign data_out   = data_out_q;
   assign rise_pulse = rise_pulse_q;
   assign fall_pulse = fall_pulse_q;
   assign busy       = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule
